// File: rtl/spi_engine_pkg.sv
// Shared definitions for the SPI master engine: register map, CTRL/STATUS
// bit positions and the transfer state encoding.
package spi_engine_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_CPOL     = 7;
    localparam int CTRL_CPHA     = 6;
    localparam int CTRL_LSBF     = 5;
    localparam int CTRL_SSEN     = 4;
    localparam int CTRL_SSEL_LSB = 0;
    localparam int CTRL_SSEL_W   = 4;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GUARD = 2'd2
    } state_e;

    // Field order mirrors the CTRL bit positions above (bit7 down to bit0).
    typedef struct packed {
        logic       cpol;
        logic       cpha;
        logic       lsbf;
        logic       ssen;
        logic [3:0] ssel;
    } ctrl_t;

endpackage

// File: rtl/spi_master_engine_if.sv
// Register-bus interface of the SPI master engine (host side = master).
interface spi_master_engine_if #(parameter int DW = 8);
    logic          WR;
    logic [1:0]    ADDR;
    logic [DW-1:0] WDATA;
    logic [DW-1:0] RDATA;
    logic          BUSY;

    modport master (output WR, ADDR, WDATA, input RDATA, BUSY);
    modport slave  (input WR, ADDR, WDATA, output RDATA, BUSY);
endinterface

// File: rtl/spi_master_engine_clkgen.sv
// SCK timing for the SPI engine: half-period divider plus edge counter,
// producing single-cycle pulses in the cycle before each SCK edge.
module spi_engine_clkgen #(
    parameter int DW   = 8,
    parameter int DIVW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            run,
    input  logic [DIVW-1:0] div,
    output logic            lead,
    output logic            trail,
    output logic            last,
    output logic            fin
);
    localparam int EW = $clog2(2 * DW + 1);
    localparam logic [EW-1:0] NEDGE = EW'(2 * DW);

    logic [DIVW-1:0] cnt_q;
    logic [EW-1:0]   ecnt_q;
    logic            tick;

    // ecnt_q counts completed edges; the tick after edge 2*DW closes the guard.
    assign tick  = run && (cnt_q == div);
    assign lead  = tick && (ecnt_q < NEDGE) && !ecnt_q[0];
    assign trail = tick && (ecnt_q < NEDGE) && ecnt_q[0];
    assign last  = trail && (ecnt_q == NEDGE - EW'(1));
    assign fin   = tick && (ecnt_q == NEDGE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            ecnt_q <= '0;
        end else if (start) begin
            cnt_q  <= '0;
            ecnt_q <= '0;
        end else if (tick) begin
            cnt_q  <= '0;
            ecnt_q <= ecnt_q + EW'(1);
        end else if (run) begin
            cnt_q  <= cnt_q + DIVW'(1);
        end
    end

endmodule

// File: rtl/spi_master_engine.sv
// SPI master shift engine behind a 4-register bus: DATA/CTRL/DIV/STATUS.
// One DATA write clocks a full word out on MOSI and assembles RX from MISO.
module spi_master_engine
    import spi_engine_pkg::*;
#(
    parameter int NSS  = 4,
    parameter int DW   = 8,
    parameter int DIVW = 4
) (
    input  logic                CLK,
    input  logic                nRESET,
    spi_master_engine_if.slave  bus,
    output logic                SCK,
    output logic                MOSI,
    input  logic [NSS-1:0]      MISO,
    output logic [NSS-1:0]      nSS
);
    localparam int SW = (NSS > 1) ? $clog2(NSS) : 1;

    state_e          state_q, state_d;
    ctrl_t           ctrl_q;
    logic [DIVW-1:0] div_q;
    logic [DW-1:0]   tx_q, sh_q, rx_q, tx_shl, wd_shl;
    logic            done_q, ovr_q, sck_ph_q, mosi_q;
    logic [NSS-1:0]  nss_q, sel_dec;
    logic            lead, trail, last, fin;
    logic            wr_data, wr_ctrl, wr_div, wr_stat;
    logic            busy, load, drop, sample, shift, lane, outbit, firstbit;

    assign busy    = (state_q != IDLE);
    assign wr_data = bus.WR && (bus.ADDR == REG_DATA);
    assign wr_ctrl = bus.WR && (bus.ADDR == REG_CTRL);
    assign wr_div  = bus.WR && (bus.ADDR == REG_DIV);
    assign wr_stat = bus.WR && (bus.ADDR == REG_STATUS);
    assign drop    = busy && (wr_data || wr_ctrl || wr_div);

    spi_engine_clkgen #(.DW(DW), .DIVW(DIVW)) u_clkgen (
        .clk   (CLK),
        .rst_n (nRESET),
        .start (load),
        .run   (busy),
        .div   (div_q),
        .lead  (lead),
        .trail (trail),
        .last  (last),
        .fin   (fin)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE:    if (wr_data) begin
                         load    = 1'b1;
                         state_d = SHIFT;
                     end
            SHIFT:   if (last) state_d = GUARD;
            GUARD:   if (fin)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CPHA picks which half of each SCK period samples and which shifts;
    // in mode 0/2 the final trailing edge has nothing left to shift.
    assign sample   = ctrl_q.cpha ? trail : lead;
    assign shift    = ctrl_q.cpha ? lead : (trail && !last);
    assign outbit   = ctrl_q.lsbf ? tx_q[0] : tx_q[DW-1];
    assign firstbit = ctrl_q.lsbf ? bus.WDATA[0] : bus.WDATA[DW-1];
    assign tx_shl   = ctrl_q.lsbf ? (tx_q >> 1) : (tx_q << 1);
    assign wd_shl   = ctrl_q.lsbf ? (bus.WDATA >> 1) : (bus.WDATA << 1);
    assign lane     = (int'(ctrl_q.ssel) < NSS) ? MISO[ctrl_q.ssel[SW-1:0]] : 1'b0;

    for (genvar i = 0; i < NSS; i++) begin : g_lane
        assign sel_dec[i] = ctrl_q.ssen && (int'(ctrl_q.ssel) == i);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            ctrl_q   <= '0;
            div_q    <= '1;
            tx_q     <= '0;
            sh_q     <= '0;
            rx_q     <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            sck_ph_q <= 1'b0;
            mosi_q   <= 1'b0;
            nss_q    <= '1;
        end else begin
            nss_q <= ~sel_dec;
            if (!busy && wr_ctrl) ctrl_q <= ctrl_t'(bus.WDATA[7:0]);
            if (!busy && wr_div)  div_q  <= bus.WDATA[DIVW-1:0];
            if (load) begin
                if (ctrl_q.cpha) begin
                    tx_q <= bus.WDATA;
                end else begin
                    tx_q   <= wd_shl;
                    mosi_q <= firstbit;
                end
            end
            if (shift) begin
                tx_q   <= tx_shl;
                mosi_q <= outbit;
            end
            if (sample)
                sh_q <= ctrl_q.lsbf ? {lane, sh_q[DW-1:1]} : {sh_q[DW-2:0], lane};
            if (lead || trail) sck_ph_q <= !sck_ph_q;
            if (fin) rx_q <= sh_q;
            // Clear first so a coincident set takes priority.
            if (wr_stat && bus.WDATA[ST_DONE-1]) done_q <= 1'b0;
            if (fin) done_q <= 1'b1;
            if (wr_stat && bus.WDATA[ST_OVR-1]) ovr_q <= 1'b0;
            if (drop) ovr_q <= 1'b1;
        end
    end

    always_comb begin
        bus.RDATA = '0;
        case (bus.ADDR)
            REG_DATA: bus.RDATA = rx_q;
            REG_CTRL: bus.RDATA[7:0] = ctrl_q;
            REG_DIV:  bus.RDATA[DIVW-1:0] = div_q;
            default:  begin
                bus.RDATA[ST_BUSY] = busy;
                bus.RDATA[ST_DONE] = done_q;
                bus.RDATA[ST_OVR]  = ovr_q;
            end
        endcase
    end

    assign bus.BUSY = busy;
    assign SCK      = sck_ph_q ^ ctrl_q.cpol;
    assign MOSI     = mosi_q;
    assign nSS      = nss_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Scoreboard bench for spi_master_engine: stimulus queues expected transfer
// results, a bus/pin monitor pops and compares them when BUSY drops.
module tb_spi_master_engine;
    import spi_engine_pkg::*;

    localparam int NSS  = 4;
    localparam int DW   = 8;
    localparam int DIVW = 4;

    logic           CLK = 1'b0;
    logic           nRESET = 1'b0;
    logic           SCK, MOSI;
    logic [NSS-1:0] MISO, nSS;

    spi_master_engine_if #(.DW(DW)) bus();

    spi_master_engine #(.NSS(NSS), .DW(DW), .DIVW(DIVW)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus.slave),
        .SCK    (SCK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .nSS    (nSS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0]  ser;
        logic [DW-1:0]  rx;
        int             len;
        logic [NSS-1:0] nss;
        logic           cpol;
        logic           cpha;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   errors  = 0;

    // Current configuration as the bench believes it to be.
    logic          cpol = 0, cpha = 0, lsbf = 0, ssen = 0, lb = 0;
    int            ssel = 0, div = 15;
    logic [DW-1:0] sw = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: serial bit i on the wire, and what a correct master assembles.
    function automatic exp_t model(logic [DW-1:0] data);
        exp_t e;
        for (int i = 0; i < DW; i++)
            e.ser[DW-1-i] = lsbf ? data[i] : data[DW-1-i];
        e.rx   = (ssel >= NSS) ? '0 : (lb ? data : sw);
        e.len  = (2 * DW + 1) * (div + 1);
        e.nss  = '1;
        if (ssen && ssel < NSS) e.nss[ssel] = 1'b0;
        e.cpol = cpol;
        e.cpha = cpha;
        return e;
    endfunction

    // Monitor state
    logic          busy_p = 0, sck_p = 0, mosi_p = 0, nss_bad = 0;
    int            edge_n = 0, nsamp = 0, blen = 0, bad = 0;
    logic [DW-1:0] ser = '0;
    int            m_idx;
    logic          m_bit;

    // Slave model: presents the next bit of sw (or echoes MOSI) on the selected lane.
    always_comb begin
        m_idx = (nsamp < DW) ? nsamp : DW - 1;
        m_bit = lb ? MOSI : (lsbf ? sw[m_idx] : sw[DW-1-m_idx]);
        MISO  = '0;
        if (ssel < NSS) MISO[ssel] = m_bit;
        else            MISO = {NSS{m_bit}};
    end

    always begin : monitor
        exp_t e;
        @(posedge CLK);
        #1;
        if (!nRESET) begin
            busy_p = 0; edge_n = 0; nsamp = 0; blen = 0; bad = 0; ser = '0; nss_bad = 0;
        end else begin
            if (bus.BUSY) begin
                if (!busy_p) begin
                    edge_n = 0; nsamp = 0; blen = 0; bad = 0; ser = '0; nss_bad = 0;
                    if (sbq.size() > 0) chk("sck_idle_start", SCK, sbq[0].cpol);
                end
                blen++;
                if (sbq.size() > 0 && nSS !== sbq[0].nss) nss_bad = 1;
                if (SCK !== sck_p) begin
                    edge_n++;
                    if (sbq.size() > 0 && ((sbq[0].cpha && edge_n % 2 == 0) ||
                                           (!sbq[0].cpha && edge_n % 2 == 1))) begin
                        if (MOSI !== mosi_p) bad++;
                        ser = {ser[DW-2:0], MOSI};
                        nsamp++;
                    end
                end
            end else if (busy_p) begin
                if (sbq.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL unexpected_done: got transfer end expected none");
                end else begin
                    e = sbq.pop_front();
                    chk("mosi_serial", ser, e.ser);
                    chk("rx", bus.RDATA, e.rx);
                    chk("busy_len", blen, e.len);
                    chk("sck_edges", edge_n, 2 * DW);
                    chk("mosi_stable_at_sample", bad, 0);
                    chk("nss_during_xfer", nss_bad, 0);
                    chk("sck_idle_end", SCK, e.cpol);
                end
                nsamp = 0;
            end
            busy_p = bus.BUSY;
        end
        sck_p  = SCK;
        mosi_p = MOSI;
    end

    task automatic wr(logic [1:0] a, logic [DW-1:0] d);
        @(negedge CLK);
        bus.WR = 1'b1; bus.ADDR = a; bus.WDATA = d;
        @(negedge CLK);
        bus.WR = 1'b0; bus.ADDR = REG_DATA; bus.WDATA = '0;
    endtask

    task automatic rd(logic [1:0] a, output logic [DW-1:0] d);
        @(negedge CLK);
        bus.ADDR = a;
        #1 d = bus.RDATA;
        bus.ADDR = REG_DATA;
    endtask

    task automatic setup(logic pol, logic pha, logic lf, logic en, int sel, int dv,
                         logic loop, logic [DW-1:0] w);
        logic [7:0] c;
        cpol = pol; cpha = pha; lsbf = lf; ssen = en; ssel = sel; div = dv; lb = loop; sw = w;
        c = {pol, pha, lf, en, 4'(sel)};
        wr(REG_CTRL, DW'(c));
        wr(REG_DIV, DW'(dv));
    endtask

    task automatic xfer(logic [DW-1:0] d);
        sbq.push_back(model(d));
        wr(REG_DATA, d);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.BUSY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 2000) begin
            vectors++; errors++;
            $display("FAIL busy_timeout: got BUSY stuck expected 0");
        end
        @(negedge CLK);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [DW-1:0] r;
        logic [31:0]   u;
        int            n;
        bus.WR = 1'b0; bus.ADDR = REG_DATA; bus.WDATA = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_sck", SCK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_nss", nSS, (1 << NSS) - 1);
        nRESET = 1'b1;
        rd(REG_DIV, r);    chk("rst_div", r, (1 << DIVW) - 1);
        rd(REG_CTRL, r);   chk("rst_ctrl", r, 0);
        rd(REG_DATA, r);   chk("rst_rx", r, 0);
        rd(REG_STATUS, r); chk("rst_status", r, 0);

        // Mode 0, MSB first, slave returns 0x3C on lane 1
        setup(0, 0, 0, 1, 1, 0, 0, 8'h3C);
        @(negedge CLK);
        chk("t1_nss", nSS, 4'b1101);
        xfer(8'hA5);
        wait_idle();
        rd(REG_STATUS, r); chk("t1_status", r, 3'b010);

        // Modes 1..3, DIV=2, loopback
        for (int m = 1; m < 4; m++) begin
            setup(m[1], m[0], 0, 1, 2, 2, 1, '0);
            @(negedge CLK);
            chk("t2_sck_idle", SCK, m[1]);
            xfer(8'h81);
            wait_idle();
        end

        // LSB first, loopback
        setup(0, 0, 1, 1, 0, 0, 1, '0);
        xfer(8'h01);
        wait_idle();

        // Writes while busy are dropped and flag OVR
        setup(0, 0, 0, 1, 2, 1, 0, 8'h5A);
        xfer(8'h96);
        repeat (5) @(negedge CLK);
        wr(REG_DATA, 8'hFF);
        wr(REG_CTRL, 8'hF3);
        wr(REG_DIV, 8'h07);
        rd(REG_CTRL, r);   chk("t4_ctrl_kept", r, 8'h12);
        rd(REG_DIV, r);    chk("t4_div_kept", r, 1);
        wait_idle();
        rd(REG_STATUS, r); chk("t4_status_ovr", r, 3'b110);
        wr(REG_STATUS, 8'h03);
        rd(REG_STATUS, r); chk("t4_status_clr", r, 0);

        // Out-of-range select
        setup(0, 0, 0, 1, 7, 0, 0, 8'hFF);
        @(negedge CLK);
        chk("t6_nss", nSS, (1 << NSS) - 1);
        xfer(8'h3C);
        wait_idle();

        // Randomized transfers
        for (int k = 0; k < 24; k++) begin
            u = $urandom;
            setup(u[0], u[1], u[2], u[3], int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 3)), u[4], DW'($urandom));
            xfer(DW'($urandom));
            wait_idle();
        end

        // Reset at SCK edge 7 of a transfer
        setup(0, 0, 0, 1, 2, 1, 0, 8'h77);
        wr(REG_DATA, 8'hC3);
        n = 0;
        while (edge_n < 7 && n < 500) begin
            @(posedge CLK);
            #2;
            n++;
        end
        chk("t5_reached_edge7", edge_n, 7);
        nRESET = 1'b0;
        #1;
        chk("t5_sck", SCK, 0);
        chk("t5_nss", nSS, (1 << NSS) - 1);
        chk("t5_busy", bus.BUSY, 0);
        chk("t5_rx", bus.RDATA, 0);
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;
        rd(REG_DIV, r);    chk("t5_div", r, (1 << DIVW) - 1);
        rd(REG_STATUS, r); chk("t5_status", r, 0);
        repeat (3) @(negedge CLK);
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
